// File: rtl/cam_capture.sv
// Camera capture front end: turns an RGB565 byte stream into RGB444 frame-buffer writes,
// discarding a few settle frames after capture is enabled and checking the size of each frame.
module cam_capture #(
  parameter int H_PIX       = 640,
  parameter int V_PIX       = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk_C,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [18:0] ram_wr_addr,
  output logic [11:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic        frame_done,
  output logic        size_err
);

  localparam int          TOTAL   = H_PIX * V_PIX;
  localparam logic [19:0] TOTAL_C = 20'(TOTAL);
  localparam logic [7:0]  SKIP_C  = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  logic [1:0]  rst_sync_r;
  logic        rst_int_n_s;
  state_t      state_r;
  logic        vs_d_r;
  logic [7:0]  skip_cnt_r;
  logic [19:0] pix_cnt_r;
  logic        ovf_r;
  logic        phase_r;
  logic [6:0]  hi_r;

  logic        rise_s;
  logic        fall_s;
  logic        pix_done_s;
  logic        room_s;
  logic [19:0] cnt_final_s;
  logic        ovf_final_s;
  logic [11:0] pix_s;

  // Reset: assert asynchronously, release two PCLK edges later.
  always_ff @(posedge clk_C or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  assign rise_s     = cam_vsync & ~vs_d_r;
  assign fall_s     = ~cam_vsync & vs_d_r;
  assign pix_done_s = (state_r == ST_CAPTURE) & cam_href & phase_r;
  assign room_s     = (pix_cnt_r < TOTAL_C);

  // RGB565 -> RGB444: hi_r already holds {R[4:1], G[5:3]}; lo supplies G[2] and B[4:1].
  assign pix_s = {hi_r, cam_data[7], cam_data[4:1]};

  // Pixel count and overflow including a pixel that completes this cycle, for the size check.
  always_comb begin
    cnt_final_s = pix_cnt_r;
    ovf_final_s = ovf_r;
    if (pix_done_s && room_s) begin
      cnt_final_s = pix_cnt_r + 20'd1;
    end else begin
      cnt_final_s = pix_cnt_r;
    end
    if (pix_done_s && !room_s) begin
      ovf_final_s = 1'b1;
    end else begin
      ovf_final_s = ovf_r;
    end
  end

  // Capture FSM with registered write port and status outputs.
  always_ff @(posedge clk_C or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r     <= ST_IDLE;
      vs_d_r      <= 1'b0;
      skip_cnt_r  <= 8'd0;
      pix_cnt_r   <= 20'd0;
      ovf_r       <= 1'b0;
      phase_r     <= 1'b0;
      hi_r        <= 7'd0;
      ram_wr_addr <= 19'd0;
      ram_wr_data <= 12'd0;
      ram_wr_en   <= 1'b0;
      frame_done  <= 1'b0;
      size_err    <= 1'b0;
    end else begin
      vs_d_r     <= cam_vsync;
      ram_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          phase_r <= 1'b0;
          if (capture_en) begin
            skip_cnt_r <= 8'd0;
            state_r    <= (SKIP_FRAMES == 0) ? ST_WAIT : ST_SKIP;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SKIP: begin
          phase_r <= 1'b0;
          if (!capture_en) begin
            state_r <= ST_IDLE;
          end else if (fall_s) begin
            skip_cnt_r <= skip_cnt_r + 8'd1;
            if ((skip_cnt_r + 8'd1) == SKIP_C) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_SKIP;
            end
          end else begin
            state_r <= ST_SKIP;
          end
        end

        ST_WAIT: begin
          if (!capture_en) begin
            state_r <= ST_IDLE;
            phase_r <= 1'b0;
          end else if (fall_s) begin
            pix_cnt_r <= 20'd0;
            ovf_r     <= 1'b0;
            phase_r   <= 1'b0;
            state_r   <= ST_CAPTURE;
          end else begin
            state_r <= ST_WAIT;
            phase_r <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          // An odd trailing byte is simply forgotten when href drops.
          if (cam_href) begin
            phase_r <= ~phase_r;
          end else begin
            phase_r <= 1'b0;
          end
          if (cam_href && !phase_r) begin
            hi_r <= {cam_data[7:4], cam_data[2:0]};
          end else begin
            hi_r <= hi_r;
          end
          if (pix_done_s && room_s) begin
            ram_wr_en   <= 1'b1;
            ram_wr_data <= pix_s;
            ram_wr_addr <= pix_cnt_r[18:0];
          end else begin
            ram_wr_en <= 1'b0;
          end
          pix_cnt_r <= cnt_final_s;
          ovf_r     <= ovf_final_s;
          if (rise_s) begin
            frame_done <= 1'b1;
            if ((cnt_final_s != TOTAL_C) || ovf_final_s) begin
              size_err <= 1'b1;
            end else begin
              size_err <= size_err;
            end
            state_r <= capture_en ? ST_WAIT : ST_IDLE;
          end else begin
            state_r <= ST_CAPTURE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          phase_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a reduced 8x4 frame: a write scoreboard plus per-frame counts.
`timescale 1ns/1ps
module tb_cam_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int SK    = 2;
  localparam int TOTAL = H * V;

  logic        clk_C      = 1'b0;
  logic        rst_n      = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync  = 1'b1;
  logic        cam_href   = 1'b0;
  logic [7:0]  cam_data   = 8'd0;
  logic [18:0] ram_wr_addr;
  logic [11:0] ram_wr_data;
  logic        ram_wr_en;
  logic        frame_done;
  logic        size_err;

  cam_capture #(.H_PIX(H), .V_PIX(V), .SKIP_FRAMES(SK)) dut (
    .clk_C(clk_C), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en), .frame_done(frame_done),
    .size_err(size_err)
  );

  always #5 clk_C = ~clk_C;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;

  localparam int NTAB = 6;
  vec_t tab [NTAB];

  int n_err = 0;
  int n_chk = 0;
  int n_wr = 0;
  int n_done = 0;
  int pix_idx = 0;
  logic [30:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] c444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  always @(negedge clk_C) begin
    logic [30:0] e;
    if (frame_done) n_done++;
    if (ram_wr_en) begin
      n_wr++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 ram_wr_addr, ram_wr_data);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", {13'd0, ram_wr_addr}, {13'd0, e[30:12]});
        chk("wr_data", {20'd0, ram_wr_data}, {20'd0, e[11:0]});
      end
    end
  end

  task automatic tick;
    @(posedge clk_C);
    #1;
  endtask

  task automatic send_line(input int nbytes, input bit cap, input bit use_tab);
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] ex;
    hi = 8'd0;
    for (int b = 0; b < nbytes; b++) begin
      cam_href = 1'b1;
      if (b % 2 == 0) begin
        if (use_tab && pix_idx < NTAB) hi = tab[pix_idx].hi;
        else hi = 8'($urandom);
        cam_data = hi;
      end else begin
        if (use_tab && pix_idx < NTAB) begin
          lo = tab[pix_idx].lo;
          ex = tab[pix_idx].exp;
        end else begin
          lo = 8'($urandom);
          ex = c444(hi, lo);
        end
        cam_data = lo;
        if (cap && pix_idx < TOTAL) sb_q.push_back({pix_idx[18:0], ex});
        pix_idx++;
      end
      tick;
    end
    cam_href = 1'b0;
    cam_data = 8'd0;
    tick;
    tick;
  endtask

  task automatic send_frame(input int lines, input int first_bytes, input bit cap,
                            input bit use_tab, input int drop_line, input string tag);
    int wr0;
    int d0;
    int expw;
    wr0 = n_wr;
    d0 = n_done;
    pix_idx = 0;
    cam_vsync = 1'b1;
    repeat (4) tick;
    cam_vsync = 1'b0;
    repeat (3) tick;
    for (int l = 0; l < lines; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      send_line((l == 0) ? first_bytes : 2 * H, cap, use_tab);
    end
    cam_vsync = 1'b1;
    repeat (4) tick;
    expw = cap ? ((pix_idx < TOTAL) ? pix_idx : TOTAL) : 0;
    chk({tag, "_writes"}, n_wr - wr0, expw);
    chk({tag, "_done"}, n_done - d0, cap ? 1 : 0);
    chk({tag, "_queue_empty"}, sb_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr"}, {13'd0, ram_wr_addr}, 32'd0);
    chk({tag, "_data"}, {20'd0, ram_wr_data}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, ram_wr_en}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_size_err"}, {31'd0, size_err}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab[0] = '{8'hF8, 8'h1F, 12'hF0F};
    tab[1] = '{8'h07, 8'hE0, 12'h0F0};
    tab[2] = '{8'hFF, 8'hFF, 12'hFFF};
    tab[3] = '{8'h00, 8'h00, 12'h000};
    tab[4] = '{8'h12, 8'h34, 12'h14A};
    tab[5] = '{8'hA5, 8'h5A, 12'hAAD};

    repeat (3) tick;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (4) tick;
    capture_en = 1'b1;
    tick;

    // Two settle frames, then a captured frame whose leading pixels come from the table.
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "skip1");
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "skip2");
    send_frame(V, 2 * H, 1'b1, 1'b1, -1, "cap3");
    chk("cap3_size_err", {31'd0, size_err}, 32'd0);

    // First line carries one extra byte; it must be dropped and addresses stay contiguous.
    send_frame(V, 2 * H + 1, 1'b1, 1'b0, -1, "oddline");
    chk("oddline_size_err", {31'd0, size_err}, 32'd0);

    // One line too many: writes stop at TOTAL-1 and the size flag sets.
    send_frame(V + 1, 2 * H, 1'b1, 1'b0, -1, "over");
    chk("over_size_err", {31'd0, size_err}, 32'd1);

    // Reset in the middle of a captured frame.
    pix_idx = 0;
    cam_vsync = 1'b1;
    repeat (4) tick;
    cam_vsync = 1'b0;
    repeat (3) tick;
    send_line(2 * H, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_outputs_zero("midreset");
    send_line(2 * H, 1'b0, 1'b0);
    chk_outputs_zero("midreset_held");
    rst_n = 1'b1;
    send_line(2 * H, 1'b0, 1'b0);
    chk("midreset_queue_empty", sb_q.size(), 0);
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "rst_skip1");
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "rst_skip2");
    chk("rst_skip_size_err", {31'd0, size_err}, 32'd0);

    // One line short after the restart.
    send_frame(V - 1, 2 * H, 1'b1, 1'b0, -1, "under");
    chk("under_size_err", {31'd0, size_err}, 32'd1);

    // Capture enable dropped mid-frame: frame completes, then the block goes idle.
    send_frame(V, 2 * H, 1'b1, 1'b0, 2, "drop");
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "after_drop");
    send_frame(V, 2 * H, 1'b0, 1'b0, -1, "after_drop2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_PIX, default 640, active pixels per line.
REQ-002 Parameter V_PIX, default 480, active lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 2, frames discarded after capture enable while the sensor settles.
REQ-004 Port clk_C  input  1  camera pixel clock (PCLK); the block's only clock, rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port capture_en  input  1  level; high requests continuous frame capture.
REQ-007 Port cam_vsync  input  1  active-high frame sync; high between frames.
REQ-008 Port cam_href  input  1  active-high line valid.
REQ-009 Port cam_data  input  8  RGB565 byte stream, high byte first.
REQ-010 Port ram_wr_addr  output  19  frame-buffer write address, row-major, pixel k at address k.
REQ-011 Port ram_wr_data  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-012 Port ram_wr_en  output  1  one-cycle write strobe per pixel.
REQ-013 Port frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-014 Port size_err  output  1  sticky flag: a captured frame had a pixel count other than H_PIX*V_PIX.

Function
REQ-015 cam_vsync is registered once (vs_d); rise = cam_vsync & ~vs_d, fall = ~cam_vsync & vs_d.
REQ-016 States: IDLE, SKIP, WAIT, CAPTURE.
REQ-017 IDLE: if capture_en, clear skip counter, go to SKIP (or WAIT if SKIP_FRAMES=0).
REQ-018 SKIP: each vsync fall increments skip counter; on the fall that brings it to SKIP_FRAMES, go to WAIT; no writes.
REQ-019 WAIT: on vsync fall, clear pixel counter and byte phase, go to CAPTURE.
REQ-020 CAPTURE: on vsync rise, pulse frame_done next cycle, then go to WAIT if capture_en high, else IDLE.
REQ-021 capture_en deassertion in SKIP or WAIT returns to IDLE next cycle; in CAPTURE it takes effect only at frame end.
REQ-022 Byte phase toggles on each clk_C edge with cam_href high in CAPTURE; forced to 0 whenever cam_href is low.
REQ-023 Phase 0 byte latched as hi; phase 1 byte lo completes a pixel.
REQ-024 Conversion: R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
REQ-025 On pixel completion, ram_wr_en, ram_wr_data and ram_wr_addr=pixel counter are registered, visible the following cycle; pixel counter then increments.
REQ-026 Writes suppressed once pixel counter reaches H_PIX*V_PIX (307200); counter saturates at 307200 and its overflow bit is held for the size check; address never exceeds 307199.
REQ-027 Odd trailing byte at href fall is discarded; no write.
REQ-028 At vsync rise in CAPTURE, if pixel count != H_PIX*V_PIX (including overflow), set size_err; cleared only by reset.
REQ-029 ram_wr_en and frame_done never high outside CAPTURE-derived events; frame_done and ram_wr_en may coincide only if the final pixel completes on the rise cycle.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, ram_wr_addr=0, ram_wr_data=0, ram_wr_en=0, frame_done=0, size_err=0, counters, phase and vs_d to 0.
REQ-031 Reset assertion mid-frame aborts immediately; after release capture restarts from IDLE including SKIP_FRAMES discard.
REQ-032 Reset release is synchronised to clk_C (two-flop deassertion synchroniser) inside the block.

Verification
REQ-033 capture_en=1, three full 640x480 frames, SKIP_FRAMES=2 -> no writes in frames 1-2; frame 3 yields 307200 strobes, addresses 0..307199, one frame_done, size_err=0.
REQ-034 Byte pair 0xF8,0x1F -> ram_wr_data=0xF0F; pair 0x07,0xE0 -> 0x0F0; pair 0xFF,0xFF -> 0xFFF.
REQ-035 Frame with 481 lines -> writes stop at address 307199, size_err=1 at vsync rise; frame with 479 lines -> size_err=1.
REQ-036 Line of 1281 bytes -> 640 writes, last byte dropped, next line starts at address 640.
REQ-037 capture_en dropped mid-frame -> frame completes, frame_done pulses, state IDLE, no further writes.
REQ-038 rst_n pulsed low mid-frame -> all outputs 0 within the reset, no writes until two further vsync falls plus one.
